nios_fprint_timestamp_master: RTL

NIOS_FPRINT_TIMESTAMP_MASTER -- requirements
Module: nios_fprint_timestamp_master

---
 rtl/nios_fprint_timestamp_master_pkg.sv | 51 +++++
 rtl/nios_fprint_timestamp_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nios_fprint_timestamp_master_pkg.sv
// Shared definitions for the Nios timestamp-timer master: FSM states,
// timer register map and control register bit positions.
package nios_fprint_timestamp_master_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG0,
    S_CFG1,
    S_CFG2,
    S_CFG3,
    S_CFG_CTRL,
    S_STOP,
    S_SNAP_W,
    S_RD6,
    S_RD7,
    S_RD8,
    S_RD9,
    S_RDLAST,
    S_DONE,
    S_ACK
  } state_t;

  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_CONTROL = 4'd1;
  localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
  localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
  localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
  localparam logic [3:0] ADDR_PERIOD3 = 4'd5;
  localparam logic [3:0] ADDR_SNAP0   = 4'd6;
  localparam logic [3:0] ADDR_SNAP1   = 4'd7;
  localparam logic [3:0] ADDR_SNAP2   = 4'd8;
  localparam logic [3:0] ADDR_SNAP3   = 4'd9;

  localparam int CTRL_IE    = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Builds a control register word from its individual bits.
  function automatic logic [15:0] ctrl_word(input logic start, input logic stop,
                                            input logic cont, input logic ie);
    logic [15:0] w;
    w = 16'h0000;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    w[CTRL_CONT]  = cont;
    w[CTRL_IE]    = ie;
    return w;
  endfunction

endpackage

// File: rtl/nios_fprint_timestamp_master.sv
// Avalon-MM master that configures, stops, snapshots and acknowledges a
// Nios-style 64-bit interval timer through its 16-bit register window.
module nios_fprint_timestamp_master
  import nios_fprint_timestamp_master_pkg::*;
#(
  parameter int IRQ_AUTO_ACK = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_config,
  input  logic [63:0] cmd_period,
  input  logic        cmd_continuous,
  input  logic        cmd_irq_en,
  input  logic        cmd_stop,
  input  logic        cmd_snap,
  output logic        busy,
  output logic [63:0] snap_value,
  output logic        snap_valid,
  output logic        timeout_pulse,
  output logic [3:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        timer_irq
);

  state_t      state;
  state_t      next_state;
  logic        accept_cfg;
  logic        ack_mask;
  logic [63:0] period_q;
  logic        cont_q;
  logic        ie_q;
  logic [47:0] shadow;

  // State register plus the one-cycle irq mask that follows every acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      ack_mask <= 1'b0;
    end else begin
      state    <= next_state;
      ack_mask <= (state == S_ACK);
    end
  end

  // Command selection in IDLE and the fixed walk through each bus sequence.
  always_comb begin
    next_state = state;
    accept_cfg = 1'b0;
    case (state)
      S_IDLE: begin
        if ((IRQ_AUTO_ACK != 0) && timer_irq && !ack_mask) begin
          next_state = S_ACK;
        end else if (cmd_stop) begin
          next_state = S_STOP;
        end else if (cmd_config) begin
          next_state = S_CFG0;
          accept_cfg = 1'b1;
        end else if (cmd_snap) begin
          next_state = S_SNAP_W;
        end
      end
      S_CFG0:     next_state = S_CFG1;
      S_CFG1:     next_state = S_CFG2;
      S_CFG2:     next_state = S_CFG3;
      S_CFG3:     next_state = S_CFG_CTRL;
      S_CFG_CTRL: next_state = S_IDLE;
      S_STOP:     next_state = S_IDLE;
      S_SNAP_W:   next_state = S_RD6;
      S_RD6:      next_state = S_RD7;
      S_RD7:      next_state = S_RD8;
      S_RD8:      next_state = S_RD9;
      S_RD9:      next_state = S_RDLAST;
      S_RDLAST:   next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      S_ACK:      next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Latches config operands on acceptance and assembles the snapshot halfwords.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q   <= 64'd0;
      cont_q     <= 1'b0;
      ie_q       <= 1'b0;
      shadow     <= 48'd0;
      snap_value <= 64'd0;
    end else begin
      if (accept_cfg) begin
        period_q <= cmd_period;
        cont_q   <= cmd_continuous;
        ie_q     <= cmd_irq_en;
      end
      case (state)
        S_RD7:    shadow[15:0]  <= avm_readdata;
        S_RD8:    shadow[31:16] <= avm_readdata;
        S_RD9:    shadow[47:32] <= avm_readdata;
        S_RDLAST: snap_value    <= {avm_readdata, shadow};
        default:  ;
      endcase
    end
  end

  // Bus outputs decoded purely from the state and latched operands.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = ADDR_STATUS;
    avm_writedata  = 16'h0000;
    case (state)
      S_CFG0: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_PERIOD0;
        avm_writedata  = period_q[15:0];
      end
      S_CFG1: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_PERIOD1;
        avm_writedata  = period_q[31:16];
      end
      S_CFG2: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_PERIOD2;
        avm_writedata  = period_q[47:32];
      end
      S_CFG3: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_PERIOD3;
        avm_writedata  = period_q[63:48];
      end
      S_CFG_CTRL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_CONTROL;
        avm_writedata  = ctrl_word(1'b1, 1'b0, cont_q, ie_q);
      end
      S_STOP: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_CONTROL;
        avm_writedata  = ctrl_word(1'b0, 1'b1, 1'b0, 1'b0);
      end
      S_SNAP_W: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_SNAP0;
      end
      S_RD6: begin
        avm_chipselect = 1'b1;
        avm_address    = ADDR_SNAP0;
      end
      S_RD7: begin
        avm_chipselect = 1'b1;
        avm_address    = ADDR_SNAP1;
      end
      S_RD8: begin
        avm_chipselect = 1'b1;
        avm_address    = ADDR_SNAP2;
      end
      S_RD9: begin
        avm_chipselect = 1'b1;
        avm_address    = ADDR_SNAP3;
      end
      S_ACK: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_STATUS;
      end
      default: ;
    endcase
  end

  assign busy          = (state != S_IDLE);
  assign snap_valid    = (state == S_DONE);
  assign timeout_pulse = (state == S_ACK);

endmodule
